// File: rtl/ls_sequencer.sv
// Multi-cycle load/store sequencer for the SPARC datapath.
// It steps one memory instruction through MAR/MDR/RAM/regfile strobes, using an MFC handshake with a bounded wait.
module ls_sequencer #(
    parameter int unsigned MFC_TIMEOUT = 15,
    parameter logic [2:0]  TT_ALIGN    = 3'b010,
    parameter logic [2:0]  TT_BUS      = 3'b011
) (
    input  logic       Clk,
    input  logic       RESET,
    input  logic       start,
    input  logic [5:0] op3,
    input  logic [4:0] rd,
    input  logic [2:0] addr_lo,
    input  logic       MFC,
    output logic       MAR_Enable,
    output logic       MDR_Enable,
    output logic       MDR_Mux_select,
    output logic       RAM_enable,
    output logic [5:0] RAM_OpCode,
    output logic       register_file,
    output logic [4:0] in_PC,
    output logic [4:0] in_PA,
    output logic [2:0] ALUB_Mux_select,
    output logic       TEMP_Enable,
    output logic       addr_plus4,
    output logic       busy,
    output logic       done,
    output logic       trap_req,
    output logic [2:0] tt
);

    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_LDD  = 6'b000011;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_STD  = 6'b000111;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_SWAP = 6'b001111;
    localparam logic [7:0] CNT_LAST = 8'(MFC_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CHK, S_ADDR, S_REQ, S_LATCH, S_TEMP,
        S_SDATA, S_SREQ, S_WB, S_DONE, S_TRAP
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] op3_q, op3_d;
    logic [4:0] rd_q, rd_d;
    logic [2:0] addr_q, addr_d;
    logic       half_q, half_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] tt_q, tt_d;

    logic is_ldd, is_std, is_swap, is_store;
    logic legal, aligned;
    logic [4:0] rd_half;

    assign is_ldd   = (op3_q == OP_LDD);
    assign is_std   = (op3_q == OP_STD);
    assign is_swap  = (op3_q == OP_SWAP);
    assign is_store = (op3_q == OP_ST) || (op3_q == OP_STB) ||
                      (op3_q == OP_STH) || (op3_q == OP_STD);
    assign rd_half  = rd_q | {4'b0000, half_q};

    always_comb begin
        legal   = 1'b1;
        aligned = 1'b1;
        case (op3_q)
            OP_LDUB, OP_LDSB, OP_STB: aligned = 1'b1;
            OP_LDUH, OP_LDSH, OP_STH: aligned = ~addr_q[0];
            OP_LD, OP_ST, OP_SWAP:    aligned = (addr_q[1:0] == 2'b00);
            OP_LDD, OP_STD:           aligned = (addr_q == 3'b000) && !rd_q[0];
            default:                  legal   = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            op3_q   <= '0;
            rd_q    <= '0;
            addr_q  <= '0;
            half_q  <= 1'b0;
            cnt_q   <= '0;
            tt_q    <= '0;
        end else begin
            state_q <= state_d;
            op3_q   <= op3_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            half_q  <= half_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op3_d   = op3_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        half_d  = half_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op3_d   = op3;
                    rd_d    = rd;
                    addr_d  = addr_lo;
                    half_d  = 1'b0;
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (!legal || !aligned) begin
                    tt_d    = TT_ALIGN;
                    state_d = S_TRAP;
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR:  state_d = is_store ? S_SDATA : S_REQ;
            S_REQ: begin
                if (MFC) begin
                    state_d = is_swap ? S_TEMP : S_LATCH;
                end else if (cnt_q == CNT_LAST) begin
                    tt_d    = TT_BUS;
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_LATCH: state_d = S_WB;
            S_TEMP:  state_d = S_SDATA;
            S_SDATA: state_d = S_SREQ;
            S_SREQ: begin
                if (MFC) begin
                    if (is_swap) begin
                        state_d = S_WB;
                    end else if (is_std && !half_q) begin
                        half_d  = 1'b1;
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    tt_d    = TT_BUS;
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WB: begin
                if (is_ldd && !half_q) begin
                    half_d  = 1'b1;
                    state_d = S_ADDR;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_TRAP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // The wait counter restarts on every fresh entry into a request state
        if ((state_d == S_REQ || state_d == S_SREQ) && state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        MAR_Enable      = 1'b0;
        MDR_Enable      = 1'b0;
        MDR_Mux_select  = 1'b0;
        RAM_enable      = 1'b0;
        RAM_OpCode      = '0;
        register_file   = 1'b0;
        in_PC           = '0;
        in_PA           = '0;
        ALUB_Mux_select = 3'b000;
        TEMP_Enable     = 1'b0;
        addr_plus4      = 1'b0;
        done            = 1'b0;
        trap_req        = 1'b0;
        case (state_q)
            S_ADDR: begin
                MAR_Enable = 1'b1;
                addr_plus4 = half_q;
            end
            S_REQ: begin
                RAM_enable     = 1'b1;
                MDR_Mux_select = 1'b1;
                RAM_OpCode     = (is_ldd || is_swap) ? OP_LD : op3_q;
            end
            S_LATCH: begin
                MDR_Enable     = 1'b1;
                MDR_Mux_select = 1'b1;
            end
            S_TEMP: begin
                MDR_Enable     = 1'b1;
                MDR_Mux_select = 1'b1;
                TEMP_Enable    = 1'b1;
            end
            S_SDATA: begin
                MDR_Enable = 1'b1;
                in_PA      = rd_half;
            end
            S_SREQ: begin
                RAM_enable = 1'b1;
                RAM_OpCode = (is_std || is_swap) ? OP_ST : op3_q;
            end
            S_WB: begin
                register_file   = 1'b1;
                in_PC           = rd_half;
                ALUB_Mux_select = is_swap ? 3'b100 : 3'b010;
            end
            S_DONE:  done     = 1'b1;
            S_TRAP:  trap_req = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign tt   = tt_q;

endmodule

// File: tb/tb_ls_sequencer.sv
// Directed bench for ls_sequencer: a table of whole instructions with per-instruction strobe statistics,
// followed by hand-written reset and start-while-busy sequences.
module tb_ls_sequencer;

    logic       Clk = 1'b0;
    logic       RESET;
    logic       start;
    logic [5:0] op3;
    logic [4:0] rd;
    logic [2:0] addr_lo;
    logic       MFC;
    logic       MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable;
    logic [5:0] RAM_OpCode;
    logic       register_file;
    logic [4:0] in_PC, in_PA;
    logic [2:0] ALUB_Mux_select;
    logic       TEMP_Enable, addr_plus4, busy, done, trap_req;
    logic [2:0] tt;

    ls_sequencer dut (
        .Clk(Clk), .RESET(RESET), .start(start), .op3(op3), .rd(rd), .addr_lo(addr_lo), .MFC(MFC),
        .MAR_Enable(MAR_Enable), .MDR_Enable(MDR_Enable), .MDR_Mux_select(MDR_Mux_select),
        .RAM_enable(RAM_enable), .RAM_OpCode(RAM_OpCode), .register_file(register_file),
        .in_PC(in_PC), .in_PA(in_PA), .ALUB_Mux_select(ALUB_Mux_select), .TEMP_Enable(TEMP_Enable),
        .addr_plus4(addr_plus4), .busy(busy), .done(done), .trap_req(trap_req), .tt(tt)
    );

    always #5 Clk = ~Clk;

    logic [31:0] outs;
    assign outs = {MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable, RAM_OpCode, register_file,
                   in_PC, in_PA, ALUB_Mux_select, TEMP_Enable, addr_plus4, busy, done, trap_req, tt};

    // d0/d1: MFC wait cycles for the first / later requests (255 = never)
    // endc: cycle of done or trap_req, start at cycle 0
    typedef struct {
        int op3, rd, addr, d0, d1;
        int endc, trap, tt;
        int mar, ap, rf, temp, ram;
        int opc, pc, alub, pa;
    } vec_t;

    vec_t tbl[21];
    int   errors = 0;
    int   checks = 0;
    int   tt_model = 0;

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row=%0d actual=%0d required=%0d", name, row, act, exp);
        end
    endtask

    task automatic run_op(input vec_t r, input int row);
        int cyc, req_idx, req_no, dly;
        int endc, trapped, n_mar, n_ap, n_rf, n_temp, n_ram, n_busy;
        int l_opc, l_pc, l_alub, l_pa;
        bit fin;
        @(negedge Clk);
        chk("idle_busy", row, busy, 0);
        start = 1'b1; op3 = 6'(r.op3); rd = 5'(r.rd); addr_lo = 3'(r.addr); MFC = 1'b1;
        cyc = 0; req_idx = 0; req_no = 0; fin = 0;
        endc = -1; trapped = 0; n_mar = 0; n_ap = 0; n_rf = 0; n_temp = 0; n_ram = 0; n_busy = 0;
        l_opc = 0; l_pc = 0; l_alub = 0; l_pa = 0;
        while (!fin && cyc < 60) begin
            @(negedge Clk);
            cyc++;
            start = 1'b0;
            if (busy)          n_busy++;
            if (MAR_Enable)    n_mar++;
            if (addr_plus4)    n_ap++;
            if (TEMP_Enable)   n_temp++;
            if (register_file) begin n_rf++; l_pc = int'(in_PC); l_alub = int'(ALUB_Mux_select); end
            if (MDR_Enable && !MDR_Mux_select) l_pa = int'(in_PA);
            if (RAM_enable) begin
                if (req_idx == 0) l_opc = int'(RAM_OpCode);
                dly = (req_no == 0) ? r.d0 : r.d1;
                MFC = (req_idx >= dly);
                req_idx++;
                n_ram++;
            end else begin
                if (req_idx != 0) req_no++;
                req_idx = 0;
                MFC = 1'b1;   // MFC outside a request must be ignored
            end
            if (done)     begin endc = cyc; fin = 1; end
            if (trap_req) begin endc = cyc; trapped = 1; fin = 1; end
        end
        if (r.trap != 0) tt_model = r.tt;
        chk("end_cycle", row, endc, r.endc);
        chk("trap", row, trapped, r.trap);
        chk("tt", row, tt, tt_model);
        chk("mar_cnt", row, n_mar, r.mar);
        chk("plus4_cnt", row, n_ap, r.ap);
        chk("rf_cnt", row, n_rf, r.rf);
        chk("temp_cnt", row, n_temp, r.temp);
        chk("ram_cycles", row, n_ram, r.ram);
        chk("ram_opcode", row, l_opc, r.opc);
        chk("wb_in_pc", row, l_pc, r.pc);
        chk("wb_alub", row, l_alub, r.alub);
        chk("sdata_in_pa", row, l_pa, r.pa);
        chk("busy_cycles", row, n_busy, r.endc);
        $display("op row=%0d op3=%b rd=%0d addr=%0d end=%0d trap=%0d tt=%0d", row, 6'(r.op3), r.rd, r.addr, endc, trapped, tt);
    endtask

    initial begin
        //              op3 rd addr d0  d1   end trap tt  mar ap rf tmp ram  opc pc alub pa
        tbl[0]  = '{0,  5,  0,  0,   0,   6,  0, 0,  1, 0, 1, 0,  1,   0,  5, 2,  0};
        tbl[1]  = '{4,  4,  4,  0,   0,   5,  0, 0,  1, 0, 0, 0,  1,   4,  0, 0,  4};
        tbl[2]  = '{7,  6,  0,  0,   0,   8,  0, 0,  2, 1, 0, 0,  2,   4,  0, 0,  7};
        tbl[3]  = '{3,  3,  0,  0,   0,   2,  1, 2,  0, 0, 0, 0,  0,   0,  0, 0,  0};
        tbl[4]  = '{2,  1,  1,  0,   0,   2,  1, 2,  0, 0, 0, 0,  0,   0,  0, 0,  0};
        tbl[5]  = '{1,  2,  7,  0,   0,   6,  0, 0,  1, 0, 1, 0,  1,   1,  2, 2,  0};
        tbl[6]  = '{15, 9,  0,  3,   0,   11, 0, 0,  1, 0, 1, 1,  5,   4,  9, 4,  9};
        tbl[7]  = '{3,  4,  0,  0,   0,   10, 0, 0,  2, 1, 2, 0,  2,   0,  5, 2,  0};
        tbl[8]  = '{0,  8,  0,  255, 0,   18, 1, 3,  1, 0, 0, 0,  15,  0,  0, 0,  0};
        tbl[9]  = '{0,  10, 4,  14,  0,   20, 0, 0,  1, 0, 1, 0,  15,  0,  10, 2, 0};
        tbl[10] = '{8,  0,  0,  0,   0,   2,  1, 2,  0, 0, 0, 0,  0,   0,  0, 0,  0};
        tbl[11] = '{6,  11, 2,  0,   0,   5,  0, 0,  1, 0, 0, 0,  1,   6,  0, 0,  11};
        tbl[12] = '{6,  11, 3,  0,   0,   2,  1, 2,  0, 0, 0, 0,  0,   0,  0, 0,  0};
        tbl[13] = '{3,  2,  0,  0,   255, 22, 1, 3,  2, 1, 1, 0,  16,  0,  2, 2,  0};
        tbl[14] = '{7,  5,  0,  0,   0,   2,  1, 2,  0, 0, 0, 0,  0,   0,  0, 0,  0};
        tbl[15] = '{15, 1,  2,  0,   0,   2,  1, 2,  0, 0, 0, 0,  0,   0,  0, 0,  0};
        tbl[16] = '{10, 7,  6,  0,   0,   6,  0, 0,  1, 0, 1, 0,  1,   10, 7, 2,  0};
        tbl[17] = '{9,  12, 3,  0,   0,   6,  0, 0,  1, 0, 1, 0,  1,   9,  12, 2, 0};
        tbl[18] = '{5,  3,  7,  0,   0,   5,  0, 0,  1, 0, 0, 0,  1,   5,  0, 0,  3};
        tbl[19] = '{4,  17, 0,  2,   0,   7,  0, 0,  1, 0, 0, 0,  3,   4,  0, 0,  17};
        tbl[20] = '{15, 20, 0,  0,   255, 21, 1, 3,  1, 0, 0, 1,  16,  4,  0, 0,  20};

        RESET = 1'b0; start = 1'b0; op3 = '0; rd = '0; addr_lo = '0; MFC = 1'b0;
        repeat (2) @(negedge Clk);
        chk("reset_outputs", -1, outs, 32'd0);
        $display("reset outs=%h", outs);
        RESET = 1'b1;

        for (int i = 0; i < 21; i++) run_op(tbl[i], i);

        // Reset asserted while a request is outstanding
        @(negedge Clk);
        op3 = 6'b000000; rd = 5'd1; addr_lo = 3'd0; start = 1'b1; MFC = 1'b0;
        @(negedge Clk); start = 1'b0;
        repeat (2) @(negedge Clk);
        chk("pre_reset_req", -2, RAM_enable, 1);
        #2 RESET = 1'b0;
        #1 chk("async_reset_outputs", -2, outs, 32'd0);
        $display("midreq reset outs=%h", outs);
        tt_model = 0;
        @(negedge Clk); RESET = 1'b1;

        // A second start during busy must be ignored
        begin
            int cyc, n_done, done_at, n_rf, l_pc, n_mar;
            @(negedge Clk);
            chk("post_reset_idle", -3, busy, 0);
            op3 = 6'b000000; rd = 5'd1; addr_lo = 3'd0; start = 1'b1; MFC = 1'b1;
            n_done = 0; done_at = -1; n_rf = 0; l_pc = 0; n_mar = 0;
            for (cyc = 1; cyc <= 15; cyc++) begin
                @(negedge Clk);
                start = (cyc == 2);
                if (cyc == 2) begin op3 = 6'b000101; rd = 5'd3; addr_lo = 3'd1; end
                if (done) begin n_done++; if (done_at < 0) done_at = cyc; end
                if (register_file) begin n_rf++; l_pc = int'(in_PC); end
                if (MAR_Enable) n_mar++;
            end
            chk("busy_start_done_at", -3, done_at, 6);
            chk("busy_start_done_cnt", -3, n_done, 1);
            chk("busy_start_rf_cnt", -3, n_rf, 1);
            chk("busy_start_in_pc", -3, l_pc, 1);
            chk("busy_start_mar_cnt", -3, n_mar, 1);
            chk("busy_start_idle", -3, busy, 0);
            $display("busy-start done_at=%0d dones=%0d rf=%0d", done_at, n_done, n_rf);
        end

        run_op(tbl[0], 99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
